// File: rtl/cla_pkg.sv
// Shared constants and configuration check for the pipelined CLA adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    // Legal when every slice is a whole number of 4-bit groups.
    function automatic bit cla_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width % GROUP_W == 0) && (width % stages == 0) &&
               ((width / stages) % GROUP_W == 0) && ((width / stages) >= GROUP_W);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined CLA adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group with group generate/propagate.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p,
    output logic       c3
);
    logic [3:0] gi, pi;
    logic       c1, c2;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c1  = gi[0] | (pi[0] & cin);
    assign c2  = gi[1] | (pi[1] & gi[0]) | (&pi[1:0] & cin);
    assign c3  = gi[2] | (pi[2] & gi[1]) | (&pi[2:1] & gi[0]) | (&pi[2:0] & cin);
    assign sum = pi ^ {c3, c2, c1, cin};

    assign g = gi[3] | (pi[3] & gi[2]) | (&pi[3:2] & gi[1]) | (&pi[3:1] & gi[0]);
    assign p = &pi;
endmodule

// File: rtl/cla_slice.sv
// One pipeline slice: 4-bit CLA groups joined by a group-level lookahead unit.
module cla_slice
    import cla_pkg::*;
#(
    parameter int S = 4
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         cin,
    output logic [S-1:0] sum,
    output logic         cout,
    output logic         c_msb
);
    localparam int NG = S / GROUP_W;

    logic [NG-1:0] gg, pg, gc3;
    logic [NG:0]   gc;
    logic          acc;
    logic          unused_c3;

    // Each group carry is a flat function of the G/P terms and cin.
    always_comb begin
        gc    = '0;
        acc   = 1'b0;
        gc[0] = cin;
        for (int i = 0; i < NG; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++) acc = gg[j] | (pg[j] & acc);
            gc[i+1] = acc;
        end
    end

    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla_group4 u_grp (
            .a   (a[i*GROUP_W +: GROUP_W]),
            .b   (b[i*GROUP_W +: GROUP_W]),
            .cin (gc[i]),
            .sum (sum[i*GROUP_W +: GROUP_W]),
            .g   (gg[i]),
            .p   (pg[i]),
            .c3  (gc3[i])
        );
    end

    assign cout      = gc[NG];
    assign c_msb     = gc3[NG-1];
    assign unused_c3 = ^gc3;
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one slice per stage, skewed operands,
// deskewed results and a stall-everything valid/ready handshake.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int S = WIDTH / STAGES;

    if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_cla_adder: illegal WIDTH/STAGES combination");
    end

    logic                     advance;
    logic [STAGES-1:0]        vld_q;
    logic [STAGES:0]          vld_pipe;
    logic [WIDTH-1:0]         b_eff;
    logic [STAGES-1:0][S-1:0] sl_a, sl_b, sl_s;
    logic [STAGES-1:0]        sl_ci, sl_co, sl_cm;
    logic [STAGES-1:0]        cq;
    logic                     ovf_q;
    logic                     unused_cm;

    assign vld_pipe     = {vld_q, bus.in_valid};
    assign advance      = bus.out_ready | ~vld_pipe[STAGES];
    assign bus.in_ready = advance;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign unused_cm    = ^sl_cm;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cq    <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_pipe[STAGES-1:0];
            cq    <= sl_co;
            ovf_q <= sl_cm[STAGES-1] ^ sl_co[STAGES-1];
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_slice
        localparam int D = STAGES - j;
        logic [S-1:0] dsk [1:D];

        if (j == 0) begin : g_head
            assign sl_a[j]  = bus.a[S-1:0];
            assign sl_b[j]  = b_eff[S-1:0];
            assign sl_ci[j] = bus.cin;
        end else begin : g_skew
            // Slice j sees its operands j cycles after capture, alongside its carry.
            logic [S-1:0] ska [1:j];
            logic [S-1:0] skb [1:j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 1; i <= j; i++) begin
                        ska[i] <= '0;
                        skb[i] <= '0;
                    end
                end else if (advance) begin
                    ska[1] <= bus.a[j*S +: S];
                    skb[1] <= b_eff[j*S +: S];
                    for (int i = 2; i <= j; i++) begin
                        ska[i] <= ska[i-1];
                        skb[i] <= skb[i-1];
                    end
                end
            end
            assign sl_a[j]  = ska[j];
            assign sl_b[j]  = skb[j];
            assign sl_ci[j] = cq[j-1];
        end

        cla_slice #(.S(S)) u_slice (
            .a     (sl_a[j]),
            .b     (sl_b[j]),
            .cin   (sl_ci[j]),
            .sum   (sl_s[j]),
            .cout  (sl_co[j]),
            .c_msb (sl_cm[j])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 1; i <= D; i++) dsk[i] <= '0;
            end else if (advance) begin
                dsk[1] <= sl_s[j];
                for (int i = 2; i <= D; i++) dsk[i] <= dsk[i-1];
            end
        end
        assign bus.sum[j*S +: S] = dsk[D];
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.cout      = cq[STAGES-1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: vector table + scoreboard on a 16/4 instance,
// plus a 4/1 instance for the single-stage corner.
module tb_pipelined_cla_adder;
    localparam int W  = 16;
    localparam int ST = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(W)) bus ();
    pipelined_cla_adder_if #(.WIDTH(4)) bus4 ();

    pipelined_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipelined_cla_adder #(.WIDTH(4), .STAGES(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    exp_t sb[$];
    exp_t me;
    vec_t vecs[9];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_out  = 0;
    logic chk_rdy = 1'b0;
    logic stalled = 1'b0;
    logic [W-1:0] h_sum;
    logic h_cout, h_ovf;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Scoreboard monitor: pops on every output transfer, checks stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (chk_rdy)
                chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
            if (stalled) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_sum",   32'(bus.sum),       32'(h_sum));
                chk("stall_cout",  32'(bus.cout),      32'(h_cout));
                chk("stall_ovf",   32'(bus.ovf),       32'(h_ovf));
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_sum   = bus.sum;
            h_cout  = bus.cout;
            h_ovf   = bus.ovf;
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("out_valid_unexpected", 32'(bus.out_valid), 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("sum",  32'(bus.sum),  32'(me.sum));
                    chk("cout", 32'(bus.cout), 32'(me.cout));
                    chk("ovf",  32'(bus.ovf),  32'(me.ovf));
                end
            end
        end
    end

    // Present one beat (entered just after a rising edge); returns just after acceptance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready) sb.push_back(e);
        else chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int   lat, i, cyc, n0;
        exp_t e;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        // Reset for 2 cycles with a beat presented that must be discarded.
        bus.in_valid = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'h0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst4_out_valid", 32'(bus4.out_valid), 32'd0);
        @(posedge clk); #1;

        // First-beat latency on an idle pipeline.
        e = '{vecs[0].sum, vecs[0].cout, vecs[0].ovf};
        send(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, e);
        lat = 1;
        while (lat <= 10) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(ST));
        @(posedge clk); #1;

        // Table vectors, back to back.
        for (int k = 0; k < 9; k++) begin
            e = '{vecs[k].sum, vecs[k].cout, vecs[k].ovf};
            send(vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, e);
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        chk("table_drain", 32'(sb.size()), 32'd0);
        #1;

        // 8-beat stream with out_ready toggling every cycle.
        n0 = n_out;
        chk_rdy = 1'b1;
        i = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        while ((i < 8 || sb.size() != 0) && cyc < 200) begin
            bus.in_valid = (i < 8);
            bus.a = W'(i);
            bus.b = W'(i * 256);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{W'(i * 257), 1'b0, 1'b0});
                i++;
            end
            @(posedge clk); #1;
            cyc++;
            bus.out_ready = ~bus.out_ready;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_drain", 32'(sb.size()), 32'd0);
        chk("stream_count", 32'(n_out - n0), 32'd8);
        @(negedge clk);
        chk_rdy = 1'b0;
        @(posedge clk); #1;

        // Reset mid-flight: three accepted beats must never appear.
        for (int k = 0; k < 3; k++) begin
            e = '{16'hDEAD, 1'b0, 1'b0};
            send(16'h0100 + W'(k), 16'h0001, 1'b0, 1'b0, e);
        end
        n0 = n_out;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (10) @(posedge clk);
        chk("rst_mid_dropped", 32'(n_out - n0), 32'd0);
        #1;

        // Single-stage corner: 4-bit, STAGES=1.
        chk("w4_in_ready", 32'(bus4.in_ready), 32'd1);
        bus4.in_valid = 1'b1; bus4.a = 4'hD; bus4.b = 4'hA; bus4.cin = 1'b0; bus4.sub = 1'b0;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("w4_out_valid", 32'(bus4.out_valid), 32'd1);
        chk("w4_sum",       32'(bus4.sum),       32'h7);
        chk("w4_cout",      32'(bus4.cout),      32'd1);
        chk("w4_ovf",       32'(bus4.ovf),       32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w4_bubble", 32'(bus4.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's 4-bit combinational CLA: N-bit operands, configurable pipeline depth, add/sub mode, carry-in, signed-overflow flag and a valid/ready stream handshake with backpressure. It sits between operand sources and datapath consumers that need full-rate throughput at higher clock frequencies than a single-cycle CLA allows.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4.
STAGES, 4, number of pipeline stages; WIDTH/STAGES must be a multiple of 4 and ≥4.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (raw; for A-B drive 1)
sub  in  1  0 = A+B+cin, 1 = A+~B+cin
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB (not-borrow in sub mode)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: single clock domain (clk); reset (rst) is synchronous and active-high.
- Slicing: stage k (0..STAGES-1) adds bits [k*S +: S], with S = WIDTH/STAGES. Each slice is built from 4-bit CLA groups with lookahead across the groups inside the slice. The slice carry-out is registered into stage k+1.
- Operand skew: the A/B(processed) bits for later slices are delayed in skew registers. Lower result bits are delayed in deskew registers so all WIDTH bits of one beat emerge together.
- Mode: b is inverted when sub=1 at stage 0 capture. sub and cin are captured with the beat.
- Handshake:
  - advance = out_ready | ~out_valid.
  - in_ready = advance, a combinational function of out_ready and out_valid only.
  - A beat is accepted when in_valid & in_ready.
  - When advance=0, every pipeline register, including the valid bits, holds its value.
- Latency: exactly STAGES cycles from acceptance to out_valid=1 when there is no backpressure. Throughput is 1 beat/cycle.
- Ordering: results come out in acceptance order, with no loss or duplication under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
- Bubbles: in_valid=0 while advancing inserts a bubble (valid bit 0). Bubbles propagate and never set out_valid.
- Reset:
  - While rst=1: all valid bits = 0, out_valid = 0, sum/cout/ovf = 0.
  - in_ready is 1 during reset (because out_valid=0), but beats presented during reset are discarded.
  - Reset mid-operation drops all in-flight beats; none of them is ever emitted.
- Width rules:
  - sum = (A + B' + cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - ovf is computed from the final stage's MSB carries.
- STAGES=1 gives a registered single-cycle CLA with latency 1.

Decomposition:
- Shared package cla_pkg: constant GROUP_W = 4, and a function that checks WIDTH/STAGES legality (used in an elaboration-time assertion).
- Sub-module cla_group4: combinational 4-bit group. Inputs a, b, cin. Outputs sum[3:0], group generate G, group propagate P, and carry into bit 3 (used for ovf).
- One slice is generate-looped from cla_group4 instances plus a group-level lookahead unit. The top level holds the pipeline, skew/deskew registers and handshake.

Test Plan:
All cases use WIDTH=16, STAGES=4 unless noted.
1. Hold rst=1 for 2 cycles, then release -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1.
2. Add a=0x1234, b=0x1111, cin=0, sub=0, out_ready=1 -> exactly 4 cycles later: sum=0x2345, cout=0, ovf=0.
3. Add boundaries:
   - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
4. Subtract (sub=1, cin=1):
   - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
5. Stream 8 beats back-to-back (a=i, b=0x0100*i) with out_ready toggling 1,0,1,0,… -> 8 results in order with sum=a+b. in_ready=0 exactly on cycles with out_valid=1 & out_ready=0. Outputs stay stable while stalled.
6. Accept 3 beats, then assert rst for 1 cycle mid-flight -> out_valid=0 from the next cycle; none of the 3 results ever appears.
7. Parameter corner, WIDTH=4, STAGES=1: a=0xD, b=0xA, add -> 1 cycle later sum=0x7, cout=1, ovf=1.
